// File: rtl/game_draw_engine.sv
// game_draw_engine: one-pixel-per-clk background/gold/stone writer for vga_adapter; DRAW_SPRITE_ROUND_EN rounds sprite corners
module game_draw_engine #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter int         GOLD_SIZE    = 8,
  parameter int         STONE_SIZE   = 10,
  parameter logic [2:0] BG_COLOUR    = 3'b100,
  parameter logic [2:0] GOLD_COLOUR  = 3'b110,
  parameter logic [2:0] STONE_COLOUR = 3'b111,
  parameter int         DONE_HOLD    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_draw_background,
  input  logic       enable_draw_gold,
  input  logic       enable_draw_stone,
  input  logic [7:0] obj_x,
  input  logic [6:0] obj_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       draw_background_done,
  output logic       draw_gold_done,
  output logic       draw_stone_done,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DRAW_BG, DRAW_OBJ, DONE} state_t;
  localparam logic [7:0] W_M1    = 8'(SCREEN_W - 1);
  localparam logic [6:0] H_M1    = 7'(SCREEN_H - 1);
  localparam logic [7:0] G_M1    = 8'(GOLD_SIZE - 1);
  localparam logic [7:0] S_M1    = 8'(STONE_SIZE - 1);
  localparam logic [7:0] HOLD_M1 = 8'(DONE_HOLD - 1);
  state_t state, state_n;
  logic [7:0] cnt_x, base_x, last_x, max_x, hold;
  logic [6:0] cnt_y, base_y, last_y, max_y;
  logic [2:0] colour, last_colour;
  logic [1:0] kind;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic drawing, last_px, clip, corner;
`ifdef DRAW_SPRITE_ROUND_EN
  logic [1:0] ex, ey;
  always_comb begin
    ex = (cnt_x == 8'd0 || cnt_x == max_x) ? 2'd0 : (cnt_x == 8'd1 || cnt_x == max_x - 8'd1) ? 2'd1 : 2'd2;
    ey = (cnt_y == 7'd0 || cnt_y == max_y) ? 2'd0 : (cnt_y == 7'd1 || cnt_y == max_y - 7'd1) ? 2'd1 : 2'd2;
    corner = state == DRAW_OBJ && ({1'b0, ex} + {1'b0, ey} <= 3'd1);
  end
`else
  assign corner = 1'b0;
`endif
  always_comb begin
    drawing    = state == DRAW_BG || state == DRAW_OBJ;
    max_x      = state == DRAW_BG ? W_M1 : kind == 2'd1 ? G_M1 : S_M1;
    max_y      = state == DRAW_BG ? H_M1 : max_x[6:0];
    sum_x      = state == DRAW_BG ? {1'b0, cnt_x} : {1'b0, base_x} + {1'b0, cnt_x};
    sum_y      = state == DRAW_BG ? {1'b0, cnt_y} : {1'b0, base_y} + {1'b0, cnt_y};
    last_px    = cnt_x == max_x && cnt_y == max_y;
    clip       = sum_x >= 9'(SCREEN_W) || sum_y >= 8'(SCREEN_H);
    vga_plot   = drawing && !clip && !corner;
    vga_x      = drawing ? sum_x[7:0] : last_x;
    vga_y      = drawing ? sum_y[6:0] : last_y;
    vga_colour = drawing ? colour : last_colour;
    busy       = state != IDLE;
    draw_background_done = state == DONE && kind == 2'd0;
    draw_gold_done       = state == DONE && kind == 2'd1;
    draw_stone_done      = state == DONE && kind == 2'd2;
    state_n = state == IDLE ? (enable_draw_background ? DRAW_BG :
                               (enable_draw_gold || enable_draw_stone) ? DRAW_OBJ : IDLE) :
              state == DONE ? (hold == HOLD_M1 ? IDLE : DONE) :
              last_px ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt_x       <= '0;
      cnt_y       <= '0;
      base_x      <= '0;
      base_y      <= '0;
      kind        <= '0;
      colour      <= '0;
      hold        <= '0;
      last_x      <= '0;
      last_y      <= '0;
      last_colour <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) begin
        cnt_x  <= '0;
        cnt_y  <= '0;
        hold   <= '0;
        base_x <= obj_x;
        base_y <= obj_y;
        kind   <= enable_draw_background ? 2'd0 : enable_draw_gold ? 2'd1 : 2'd2;
        colour <= enable_draw_background ? BG_COLOUR : enable_draw_gold ? GOLD_COLOUR : STONE_COLOUR;
      end else if (drawing) begin
        cnt_x       <= cnt_x == max_x ? 8'd0 : cnt_x + 8'd1;
        cnt_y       <= cnt_x == max_x ? cnt_y + 7'd1 : cnt_y;
        last_x      <= vga_x;
        last_y      <= vga_y;
        last_colour <= vga_colour;
      end else if (state == DONE) begin
        hold <= hold + 8'd1;
      end
    end
  end
endmodule
